pll_domain_manager: RTL and testbench
=====================================

# pll_domain_manager

Parametrised lock supervisor and clock-enable generator for a PLL-derived clock domain. Runs on the PLL output clock and synchronises the PLL `LOCK` signal. It requires lock to stay stable before releasing a domain reset, then produces NUM_CH independently divided single-cycle clock-enable pulses. Loss of lock tears the domain down and restarts the sequence; an optional counter records lock-loss events for debug.

## Interface
Parameters:
- NUM_CH, 4: number of clock-enable channels (1..16).
- DIV_WIDTH, 16: width of each channel divisor.
- LOCK_STABLE, 1024: cycles synchronised lock must stay high before the domain reset is released (≥1).
- RESET_HOLD, 16: cycles after reset release during which ticks stay suppressed (≥1).
- LOSS_CNT_WIDTH, 8: width of the lock-loss counter.

Ports:
- clock_in, in, 1: PLL output clock; the only clock. One clock; reset is synchronous and active-low.
- reset_n, in, 1: synchronous active-low reset.
- pll_locked, in, 1: PLL `LOCK` output; asynchronous to clock_in.
- divisor, in, NUM_CH*DIV_WIDTH: channel i divisor is `[i*DIV_WIDTH +: DIV_WIDTH]`. Values 0 and 1 both mean "every cycle".
- ch_enable, in, NUM_CH: per-channel run enable.
- tick, out, NUM_CH: one-cycle enable pulses.
- domain_reset_n, out, 1: active-low reset for downstream logic.
- ready, out, 1: high in RUN.
- loss_count, out, LOSS_CNT_WIDTH: saturating lock-loss count. Present only with the macro.

## Operation
- `pll_locked` passes through a 2-flop synchroniser, reset to 0; the output is `lock_s`.
- FSM states:
  - WAIT_LOCK: entered on reset. Go to STABLE when lock_s=1; clear the stability counter.
  - STABLE: counter increments each cycle. lock_s=0 returns to WAIT_LOCK. Go to HOLD when the counter reaches LOCK_STABLE-1 with lock_s=1.
  - HOLD: domain_reset_n=1; ticks suppressed. Counts RESET_HOLD cycles, then goes to RUN. lock_s=0 returns to WAIT_LOCK.
  - RUN: ready=1; ticks active. lock_s=0 returns to WAIT_LOCK and increments loss_count (saturates at all-ones).
- domain_reset_n=0 in WAIT_LOCK and STABLE; 1 in HOLD and RUN. ready=1 only in RUN.
- Channel i with effective divisor D = max(divisor_i, 1):
  - Counter cnt runs only while in RUN and ch_enable[i]=1; otherwise cnt=0 and tick[i]=0.
  - When cnt ≥ D-1: cnt←0 and tick[i]=1 next cycle. Otherwise cnt←cnt+1.
  - Period is exactly D cycles. The first pulse comes D cycles after the later of RUN entry or ch_enable rise.
- A divisor change takes effect immediately. If cnt ≥ new D-1, the channel wraps and ticks on the next edge; it never stalls.
- Channels are fully independent. ch_enable falling clears cnt on the next edge; a restart begins a fresh period.

## Timing
- All outputs are registered. Reset values: tick=0, domain_reset_n=0, ready=0, loss_count=0, state WAIT_LOCK.
- Lock rise: let edge 0 be the first edge sampling pll_locked=1.
  - lock_s=1 after edge 1; STABLE after edge 2.
  - domain_reset_n=1 after edge 2+LOCK_STABLE.
  - ready=1 after edge 2+LOCK_STABLE+RESET_HOLD.
- Lock loss: the state leaves RUN/HOLD/STABLE 2 edges after pll_locked falls. On that same edge: tick=0, ready=0, domain_reset_n=0.
- A lock glitch shorter than one cycle may be missed; any glitch lasting ≥2 cycles is always seen.
- Reset mid-operation: everything returns to reset values on the next edge, including the synchroniser and loss_count.
- Simultaneous reset_n=0 and a lock event: reset wins.

## Configuration
- PLLMGR_LOSS_COUNT_EN defined: loss_count port and counter exist, behaving as above.
- Not defined: the port and counter are absent. The FSM and ticks are unchanged.

## Structure
- Package `pll_mgr_pkg`: state enum (WAIT_LOCK, STABLE, HOLD, RUN) and the `clog2`-based counter-width constants for LOCK_STABLE and RESET_HOLD.
- Sub-module `clock_enable_divider`: one channel (divisor, enable, run → tick), instantiated NUM_CH times with a generate loop.

## Test plan
- Startup: LOCK_STABLE=8, RESET_HOLD=4, pll_locked rises at edge 0 → domain_reset_n rises after edge 10, ready after edge 14.
- Glitch: pll_locked low for 3 cycles during STABLE → counter restarts and domain_reset_n stays 0 until a full 8 more stable cycles.
- Dividers: divisors {0,1,3,5}, all enabled in RUN → tick periods 1,1,3,5 cycles; first pulses at 1,1,3,5 cycles after RUN entry.
- Divisor shrink: divisor 10→2 while cnt=6 → tick on next edge, then period 2.
- Lock loss: drop pll_locked in RUN, three times → ticks and ready fall 2 edges later, and loss_count=3 with the macro. Restore lock → full sequence repeats.
- Saturation and reset: LOSS_CNT_WIDTH=2, 5 losses → loss_count=3. reset_n=0 mid-RUN → all outputs 0 after one edge.

Source files
------------

// File: rtl/pll_mgr_pkg.sv
// Shared types and width helpers for the PLL domain manager.
// Optional lock-loss counter is enabled with PLLMGR_LOSS_COUNT_EN.
package pll_mgr_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    // Bits needed for a counter that runs from 0 to n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_LOCK_STABLE = 1024;
    localparam int unsigned DEF_RESET_HOLD  = 16;
    localparam int unsigned LOCK_CNT_W      = cnt_width(DEF_LOCK_STABLE);
    localparam int unsigned HOLD_CNT_W      = cnt_width(DEF_RESET_HOLD);

endpackage

// File: rtl/pll_domain_manager_clock_enable_divider.sv
// One clock-enable channel: divides clock_in by max(divisor, 1) while run and enable are high.
module clock_enable_divider #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 enable,
    input  logic                 run,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] last;

    // Divisors 0 and 1 both terminate at count 0, giving a tick every cycle.
    always_comb begin
        last = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
    end

    // A '>=' compare lets a shrinking divisor wrap immediately instead of stalling.
    always_ff @(posedge clock_in) begin
        if (!reset_n || !run || !enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_WIDTH'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_domain_manager.sv
// Lock supervisor and NUM_CH clock-enable generator for a PLL-derived domain.
// Define PLLMGR_LOSS_COUNT_EN to add the saturating loss_count debug port.
import pll_mgr_pkg::*;

module pll_domain_manager #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DIV_WIDTH      = 16,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned RESET_HOLD     = 16,
    parameter int unsigned LOSS_CNT_WIDTH = 8
) (
    input  logic                        clock_in,
    input  logic                        reset_n,
    input  logic                        pll_locked,
    input  logic [NUM_CH*DIV_WIDTH-1:0] divisor,
    input  logic [NUM_CH-1:0]           ch_enable,
    output logic [NUM_CH-1:0]           tick,
    output logic                        domain_reset_n,
    output logic                        ready
`ifdef PLLMGR_LOSS_COUNT_EN
    ,
    output logic [LOSS_CNT_WIDTH-1:0]   loss_count
`endif
);

    localparam int unsigned SEQ_CNT_W =
        (cnt_width(LOCK_STABLE) > cnt_width(RESET_HOLD)) ? cnt_width(LOCK_STABLE)
                                                         : cnt_width(RESET_HOLD);
    localparam logic [SEQ_CNT_W-1:0] STABLE_LAST = SEQ_CNT_W'(LOCK_STABLE - 1);
    localparam logic [SEQ_CNT_W-1:0] HOLD_LAST   = SEQ_CNT_W'(RESET_HOLD - 1);

    if (NUM_CH < 1 || NUM_CH > 16 || LOCK_STABLE < 1 || RESET_HOLD < 1 ||
        DIV_WIDTH < 1 || LOSS_CNT_WIDTH < 1) begin : g_param_check
        $error("pll_domain_manager: parameter out of range");
    end

    logic [1:0]           sync_q;
    logic                 lock_s;
    state_t               state;
    state_t               state_next;
    logic [SEQ_CNT_W-1:0] seq_cnt;
    logic [SEQ_CNT_W-1:0] seq_cnt_next;
    logic                 ch_run;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_s = sync_q[1];

    // Outputs are registered from state_next so they change on the same edge as the state.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state          <= WAIT_LOCK;
            seq_cnt        <= '0;
            domain_reset_n <= 1'b0;
            ready          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state          <= state_next;
            seq_cnt        <= seq_cnt_next;
            domain_reset_n <= (state_next == HOLD) || (state_next == RUN);
            ready          <= (state_next == RUN);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        state_next   = state;
        seq_cnt_next = seq_cnt;
        unique case (state)
            WAIT_LOCK: begin
                seq_cnt_next = '0;
                if (lock_s) state_next = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next   = WAIT_LOCK;
                    seq_cnt_next = '0;
                end else if (seq_cnt == STABLE_LAST) begin
                    state_next   = HOLD;
                    seq_cnt_next = '0;
                end else begin
                    seq_cnt_next = seq_cnt + SEQ_CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next   = WAIT_LOCK;
                    seq_cnt_next = '0;
                end else if (seq_cnt == HOLD_LAST) begin
                    state_next   = RUN;
                    seq_cnt_next = '0;
                end else begin
                    seq_cnt_next = seq_cnt + SEQ_CNT_W'(1);
                end
            end
            RUN: begin
                seq_cnt_next = '0;
                if (!lock_s) state_next = WAIT_LOCK;
            end
            default: begin
                state_next   = WAIT_LOCK;
                seq_cnt_next = '0;
            end
        endcase
    end

    // Channels run only while RUN persists, so ticks drop on the same edge the state leaves RUN.
    assign ch_run = (state == RUN) && (state_next == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_enable_divider #(
            .DIV_WIDTH(DIV_WIDTH)
        ) u_div (
            .clock_in(clock_in),
            .reset_n (reset_n),
            .divisor (divisor[i*DIV_WIDTH +: DIV_WIDTH]),
            .enable  (ch_enable[i]),
            .run     (ch_run),
            .tick    (tick[i])
        );
    end

`ifdef PLLMGR_LOSS_COUNT_EN
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            loss_count <= '0;
        end else if ((state == RUN) && !lock_s && (loss_count != '1)) begin
            loss_count <= loss_count + LOSS_CNT_WIDTH'(1);
        end
    end
`else
    // Lock-loss counter not built in this configuration.
`endif

endmodule

// File: tb/tb_pll_domain_manager.sv
// Directed, table-driven bench for pll_domain_manager (LOCK_STABLE=8, RESET_HOLD=4, loss width 2).
module tb_pll_domain_manager;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned LS        = 8;
    localparam int unsigned RH        = 4;
    localparam int unsigned LCW       = 2;
    localparam int          LOSS_MAX  = 3;

    logic                        clock_in = 1'b0;
    logic                        reset_n;
    logic                        pll_locked;
    logic [NUM_CH*DIV_WIDTH-1:0] divisor;
    logic [NUM_CH-1:0]           ch_enable;
    logic [NUM_CH-1:0]           tick;
    logic                        domain_reset_n;
    logic                        ready;
`ifdef PLLMGR_LOSS_COUNT_EN
    logic [LCW-1:0]              loss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_loss = 0;

    always #5 clock_in = ~clock_in;

    pll_domain_manager #(
        .NUM_CH        (NUM_CH),
        .DIV_WIDTH     (DIV_WIDTH),
        .LOCK_STABLE   (LS),
        .RESET_HOLD    (RH),
        .LOSS_CNT_WIDTH(LCW)
    ) dut (
        .clock_in      (clock_in),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .divisor       (divisor),
        .ch_enable     (ch_enable),
        .tick          (tick),
        .domain_reset_n(domain_reset_n),
        .ready         (ready)
`ifdef PLLMGR_LOSS_COUNT_EN
        ,
        .loss_count    (loss_count)
`endif
    );

    typedef struct {
        int         e;
        logic       drn;
        logic       rdy;
        logic [3:0] tk;
    } start_vec_t;

    typedef struct {
        int         k;
        logic [3:0] tk;
    } div_vec_t;

    start_vec_t start_tab[5];
    div_vec_t   div_tab[10];

    task automatic advance(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_loss();
`ifdef PLLMGR_LOSS_COUNT_EN
        check("loss_count", 32'(loss_count), 32'(exp_loss));
`endif
    endtask

    task automatic set_div(input int ch, input int val);
        divisor[ch*DIV_WIDTH +: DIV_WIDTH] = DIV_WIDTH'(val);
    endtask

    // Called just after the edge preceding the first edge that samples pll_locked=1.
    task automatic do_startup();
        int e;
        e = -1;
        for (int i = 0; i < 5; i++) begin
            advance(start_tab[i].e - e);
            e = start_tab[i].e;
            check($sformatf("startup_drn_e%0d", e), 32'(domain_reset_n), 32'(start_tab[i].drn));
            check($sformatf("startup_ready_e%0d", e), 32'(ready), 32'(start_tab[i].rdy));
            check($sformatf("startup_tick_e%0d", e), 32'(tick), 32'(start_tab[i].tk));
        end
    endtask

    // Requires RUN with channel 0 ticking every cycle.
    task automatic lose_lock();
        pll_locked = 1'b0;
        advance(1);
        check("loss_ready_e0", 32'(ready), 32'd1);
        advance(1);
        check("loss_ready_e1", 32'(ready), 32'd1);
        check("loss_tick0_e1", 32'(tick[0]), 32'd1);
        advance(1);
        check("loss_ready_e2", 32'(ready), 32'd0);
        check("loss_drn_e2", 32'(domain_reset_n), 32'd0);
        check("loss_tick_e2", 32'(tick), 32'd0);
        exp_loss = (exp_loss < LOSS_MAX) ? exp_loss + 1 : LOSS_MAX;
        check_loss();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start_tab[0] = '{e: 1,  drn: 1'b0, rdy: 1'b0, tk: 4'h0};
        start_tab[1] = '{e: 9,  drn: 1'b0, rdy: 1'b0, tk: 4'h0};
        start_tab[2] = '{e: 10, drn: 1'b1, rdy: 1'b0, tk: 4'h0};
        start_tab[3] = '{e: 13, drn: 1'b1, rdy: 1'b0, tk: 4'h0};
        start_tab[4] = '{e: 14, drn: 1'b1, rdy: 1'b1, tk: 4'h0};

        // Divisors {0,1,3,5}: bits 0,1 every cycle, bit 2 every 3rd, bit 3 every 5th.
        div_tab[0] = '{k: 1,  tk: 4'h3};
        div_tab[1] = '{k: 2,  tk: 4'h3};
        div_tab[2] = '{k: 3,  tk: 4'h7};
        div_tab[3] = '{k: 4,  tk: 4'h3};
        div_tab[4] = '{k: 5,  tk: 4'hB};
        div_tab[5] = '{k: 6,  tk: 4'h7};
        div_tab[6] = '{k: 7,  tk: 4'h3};
        div_tab[7] = '{k: 8,  tk: 4'h3};
        div_tab[8] = '{k: 9,  tk: 4'h7};
        div_tab[9] = '{k: 10, tk: 4'hB};

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        ch_enable  = '0;
        divisor    = '0;
        set_div(0, 0);
        set_div(1, 1);
        set_div(2, 3);
        set_div(3, 5);

        advance(3);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_drn", 32'(domain_reset_n), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check_loss();

        reset_n = 1'b1;
        advance(2);
        check("wait_lock_drn", 32'(domain_reset_n), 32'd0);

        ch_enable  = 4'hF;
        pll_locked = 1'b1;
        do_startup();

        for (int i = 0; i < 10; i++) begin
            advance(1);
            check($sformatf("div_tick_k%0d", div_tab[i].k), 32'(tick), 32'(div_tab[i].tk));
        end

        // Channel 3 counter is 0 here; grow the divisor, let it reach 6, then shrink to 2.
        set_div(3, 10);
        for (int i = 0; i < 6; i++) begin
            advance(1);
            check($sformatf("grow_tick3_%0d", i), 32'(tick[3]), 32'd0);
        end
        set_div(3, 2);
        advance(1);
        check("shrink_tick3_wrap", 32'(tick[3]), 32'd1);
        advance(1);
        check("shrink_tick3_gap", 32'(tick[3]), 32'd0);
        advance(1);
        check("shrink_tick3_period", 32'(tick[3]), 32'd1);

        ch_enable[2] = 1'b0;
        advance(1);
        check("disable_tick2", 32'(tick[2]), 32'd0);
        ch_enable[2] = 1'b1;
        advance(1);
        check("restart_tick2_1", 32'(tick[2]), 32'd0);
        advance(1);
        check("restart_tick2_2", 32'(tick[2]), 32'd0);
        advance(1);
        check("restart_tick2_3", 32'(tick[2]), 32'd1);
        check("restart_tick01", 32'(tick[1:0]), 32'd3);
        advance(3);
        check("restart_tick2_6", 32'(tick[2]), 32'd1);

        lose_lock();

        // Relock with a 3-cycle dropout during STABLE.
        pll_locked = 1'b1;
        advance(5);
        check("glitch_drn_e4", 32'(domain_reset_n), 32'd0);
        pll_locked = 1'b0;
        advance(3);
        pll_locked = 1'b1;
        advance(3);
        check("glitch_drn_e10", 32'(domain_reset_n), 32'd0);
        advance(7);
        check("glitch_drn_e17", 32'(domain_reset_n), 32'd0);
        advance(1);
        check("glitch_drn_e18", 32'(domain_reset_n), 32'd1);
        check("glitch_ready_e18", 32'(ready), 32'd0);
        advance(4);
        check("glitch_ready_e22", 32'(ready), 32'd1);

        for (int n = 0; n < 4; n++) begin
            lose_lock();
            pll_locked = 1'b1;
            do_startup();
        end

        advance(3);
        reset_n = 1'b0;
        advance(1);
        check("midrun_reset_tick", 32'(tick), 32'd0);
        check("midrun_reset_drn", 32'(domain_reset_n), 32'd0);
        check("midrun_reset_ready", 32'(ready), 32'd0);
        exp_loss = 0;
        check_loss();
        advance(2);
        check("reset_wins_ready", 32'(ready), 32'd0);
        check("reset_wins_drn", 32'(domain_reset_n), 32'd0);
        reset_n = 1'b1;
        do_startup();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
